// File: rtl/writeback_unit_if.sv
// Writeback unit port bundle: upstream result, memory return,
// register file write side and status.
interface writeback_unit_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_rd;
   logic            in_wen;
   logic            in_is_load;
   logic [XLEN-1:0] in_alu_result;
   logic [2:0]      in_load_fmt;
   logic [2:0]      in_addr_low;

   logic            mem_rvalid;
   logic [63:0]     mem_rdata;

   logic            rf_wen;
   logic [4:0]      rf_rdAddr;
   logic [XLEN-1:0] rf_dataBack;

   logic            busy;
   logic [31:0]     retire_cnt;

   modport master (
      output in_valid,
      input  in_ready,
      output in_rd,
      output in_wen,
      output in_is_load,
      output in_alu_result,
      output in_load_fmt,
      output in_addr_low,
      output mem_rvalid,
      output mem_rdata,
      input  rf_wen,
      input  rf_rdAddr,
      input  rf_dataBack,
      input  busy,
      input  retire_cnt
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_rd,
      input  in_wen,
      input  in_is_load,
      input  in_alu_result,
      input  in_load_fmt,
      input  in_addr_low,
      input  mem_rvalid,
      input  mem_rdata,
      output rf_wen,
      output rf_rdAddr,
      output rf_dataBack,
      output busy,
      output retire_cnt
   );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: holds one result, waits for load data if needed,
// extracts/extends it and commits a single register file write.
module writeback_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   writeback_unit_if.slave wb
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_MEM,
      COMMIT
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic            accept;
   logic            mem_hit;

   logic [4:0]      rd_q;
   logic            wen_q;
   logic [2:0]      fmt_q;
   logic [2:0]      addr_q;

   logic [4:0]      rdaddr_q;
   logic [XLEN-1:0] data_q;
   logic [31:0]     retire_q;

   logic [XLEN-1:0] load_data;

   // Pick the addressed lane and extend it; low bits below the
   // access size are dropped, so misaligned addresses just align.
   function automatic logic [63:0] extract(
      input logic [2:0]  fmt,
      input logic [2:0]  a,
      input logic [63:0] d
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      logic [63:0] r;
      b = d[{a, 3'b000} +: 8];
      h = d[{a[2:1], 4'b0000} +: 16];
      w = d[{a[2], 5'b00000} +: 32];
      r = '0;
      unique case (fmt)
         3'b000:  r = {{56{b[7]}}, b};
         3'b001:  r = {{48{h[15]}}, h};
         3'b010:  r = {{32{w[31]}}, w};
         3'b011:  r = d;
         3'b100:  r = {56'd0, b};
         3'b101:  r = {48'd0, h};
         3'b110:  r = {32'd0, w};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Load data as seen from the latched format and address.
   always_comb begin
      load_data = XLEN'(extract(fmt_q, addr_q, wb.mem_rdata));
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      mem_hit  = 1'b0;
      unique case (state)
         IDLE: begin
            if (wb.in_valid) begin
               accept   = 1'b1;
               state_nx = wb.in_is_load ? WAIT_MEM : COMMIT;
            end
         end
         WAIT_MEM: begin
            if (wb.mem_rvalid) begin
               mem_hit  = 1'b1;
               state_nx = COMMIT;
            end
         end
         COMMIT: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Capture the instruction attributes on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q   <= '0;
         wen_q  <= 1'b0;
         fmt_q  <= '0;
         addr_q <= '0;
      end else if (accept) begin
         rd_q   <= wb.in_rd;
         wen_q  <= wb.in_wen;
         fmt_q  <= wb.in_load_fmt;
         addr_q <= wb.in_addr_low;
      end
   end

   // Write index/data only move on the edge that enters COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdaddr_q <= '0;
         data_q   <= '0;
      end else if (accept && !wb.in_is_load) begin
         rdaddr_q <= wb.in_rd;
         data_q   <= wb.in_alu_result;
      end else if (mem_hit) begin
         rdaddr_q <= rd_q;
         data_q   <= load_data;
      end
   end

   // Retire count bumps as COMMIT is entered, so it is already
   // current during the write cycle; it wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_q <= '0;
      end else if (state_nx == COMMIT && state != COMMIT) begin
         retire_q <= retire_q + 32'd1;
      end
   end

   assign wb.in_ready    = (state == IDLE);
   assign wb.busy        = (state != IDLE);
   assign wb.rf_wen      = (state == COMMIT) && wen_q && (rd_q != 5'd0);
   assign wb.rf_rdAddr   = rdaddr_q;
   assign wb.rf_dataBack = data_q;
   assign wb.retire_cnt  = retire_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, load extraction,
// x0 handling, reset abort and retire counter wrap.
module tb_writeback_unit;

   logic clk;
   logic rst;

   int n_chk;
   int n_err;
   logic [31:0] exp_cnt;

   writeback_unit_if #(.XLEN(64)) wb ();

   writeback_unit #(.XLEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Present one instruction for one cycle starting in IDLE;
   // returns at the negedge right after the accepting edge.
   task automatic issue(
      input logic        ld,
      input logic [4:0]  rd,
      input logic        wen,
      input logic [63:0] alu,
      input logic [2:0]  fmt,
      input logic [2:0]  addr
   );
      @(negedge clk);
      wb.in_valid      = 1'b1;
      wb.in_is_load    = ld;
      wb.in_rd         = rd;
      wb.in_wen        = wen;
      wb.in_alu_result = alu;
      wb.in_load_fmt   = fmt;
      wb.in_addr_low   = addr;
      @(negedge clk);
      wb.in_valid      = 1'b0;
   endtask

   task automatic mem_pulse(input logic [63:0] d);
      @(negedge clk);
      wb.mem_rvalid = 1'b1;
      wb.mem_rdata  = d;
      @(negedge clk);
      wb.mem_rvalid = 1'b0;
      wb.mem_rdata  = '0;
   endtask

   logic [2:0]  t_fmt  [6];
   logic [2:0]  t_addr [6];
   logic [63:0] t_exp  [6];

   initial begin
      n_chk   = 0;
      n_err   = 0;
      exp_cnt = 0;

      t_fmt[0] = 3'b001; t_addr[0] = 3'd7; t_exp[0] = 64'hFFFF_FFFF_FFFF_8001;
      t_fmt[1] = 3'b101; t_addr[1] = 3'd1; t_exp[1] = 64'h0000_0000_0000_ABCD;
      t_fmt[2] = 3'b100; t_addr[2] = 3'd0; t_exp[2] = 64'h0000_0000_0000_00CD;
      t_fmt[3] = 3'b011; t_addr[3] = 3'd5; t_exp[3] = 64'h8001_2345_6789_ABCD;
      t_fmt[4] = 3'b111; t_addr[4] = 3'd0; t_exp[4] = 64'h0;
      t_fmt[5] = 3'b010; t_addr[5] = 3'd3; t_exp[5] = 64'h0000_0000_6789_ABCD;

      rst              = 1'b1;
      wb.in_valid      = 1'b0;
      wb.in_rd         = '0;
      wb.in_wen        = 1'b0;
      wb.in_is_load    = 1'b0;
      wb.in_alu_result = '0;
      wb.in_load_fmt   = '0;
      wb.in_addr_low   = '0;
      wb.mem_rvalid    = 1'b0;
      wb.mem_rdata     = '0;

      repeat (2) @(negedge clk);
      chk("rst_wen",   wb.rf_wen,      0);
      chk("rst_rd",    wb.rf_rdAddr,   0);
      chk("rst_data",  wb.rf_dataBack, 0);
      chk("rst_cnt",   wb.retire_cnt,  0);
      chk("rst_busy",  wb.busy,        0);
      chk("rst_ready", wb.in_ready,    1);
      rst = 1'b0;

      // ALU write
      issue(1'b0, 5'd5, 1'b1, 64'h1234, 3'd0, 3'd0);
      exp_cnt++;
      chk("alu_wen",   wb.rf_wen,      1);
      chk("alu_rd",    wb.rf_rdAddr,   5);
      chk("alu_data",  wb.rf_dataBack, 64'h1234);
      chk("alu_cnt",   wb.retire_cnt,  exp_cnt);
      chk("alu_ready", wb.in_ready,    0);
      @(negedge clk);
      chk("alu_ready2", wb.in_ready,    1);
      chk("alu_wen2",   wb.rf_wen,      0);
      chk("alu_hold",   wb.rf_dataBack, 64'h1234);

      // LB sign extension, data three cycles after accept
      issue(1'b1, 5'd7, 1'b1, 64'h0, 3'b000, 3'd3);
      chk("lb_busy",  wb.busy,     1);
      chk("lb_ready", wb.in_ready, 0);
      chk("lb_wait",  wb.rf_wen,   0);
      @(negedge clk);
      chk("lb_wait2", wb.rf_wen,   0);
      mem_pulse(64'h0000_0000_8000_0000);
      exp_cnt++;
      chk("lb_wen",  wb.rf_wen,      1);
      chk("lb_rd",   wb.rf_rdAddr,   7);
      chk("lb_data", wb.rf_dataBack, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_cnt",  wb.retire_cnt,  exp_cnt);

      // LWU / LW upper word
      issue(1'b1, 5'd8, 1'b1, 64'h0, 3'b110, 3'd4);
      mem_pulse(64'hDEAD_BEEF_0000_0000);
      exp_cnt++;
      chk("lwu_data", wb.rf_dataBack, 64'h0000_0000_DEAD_BEEF);
      chk("lwu_cnt",  wb.retire_cnt,  exp_cnt);
      issue(1'b1, 5'd9, 1'b1, 64'h0, 3'b010, 3'd4);
      mem_pulse(64'hDEAD_BEEF_0000_0000);
      exp_cnt++;
      chk("lw_data", wb.rf_dataBack, 64'hFFFF_FFFF_DEAD_BEEF);
      chk("lw_rd",   wb.rf_rdAddr,   9);

      // Format / alignment table
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, 5'(10 + i), 1'b1, 64'h0, t_fmt[i], t_addr[i]);
         mem_pulse(64'h8001_2345_6789_ABCD);
         exp_cnt++;
         chk($sformatf("tbl%0d_wen", i),  wb.rf_wen,      1);
         chk($sformatf("tbl%0d_rd", i),   wb.rf_rdAddr,   10 + i);
         chk($sformatf("tbl%0d_data", i), wb.rf_dataBack, t_exp[i]);
         chk($sformatf("tbl%0d_cnt", i),  wb.retire_cnt,  exp_cnt);
      end

      // Stray mem_rvalid in IDLE
      mem_pulse(64'hFFFF_FFFF_FFFF_FFFF);
      chk("idle_rv_busy", wb.busy,        0);
      chk("idle_rv_wen",  wb.rf_wen,      0);
      chk("idle_rv_cnt",  wb.retire_cnt,  exp_cnt);
      chk("idle_rv_data", wb.rf_dataBack, 64'h0000_0000_6789_ABCD);

      // x0 is never written, but the instruction retires
      issue(1'b0, 5'd0, 1'b1, 64'hFF, 3'd0, 3'd0);
      exp_cnt++;
      chk("x0_wen",  wb.rf_wen,     0);
      chk("x0_busy", wb.busy,       1);
      chk("x0_cnt",  wb.retire_cnt, exp_cnt);

      // wen=0 retires without a write
      issue(1'b0, 5'd3, 1'b0, 64'h55, 3'd0, 3'd0);
      exp_cnt++;
      chk("nowen_wen", wb.rf_wen,     0);
      chk("nowen_cnt", wb.retire_cnt, exp_cnt);

      // Reset while waiting for memory
      issue(1'b1, 5'd4, 1'b1, 64'h0, 3'b011, 3'd0);
      chk("rml_busy", wb.busy, 1);
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      chk("rml_busy0", wb.busy,        0);
      chk("rml_ready", wb.in_ready,    1);
      chk("rml_cnt0",  wb.retire_cnt,  0);
      chk("rml_rd0",   wb.rf_rdAddr,   0);
      chk("rml_data0", wb.rf_dataBack, 0);
      @(negedge clk);
      rst = 1'b0;
      mem_pulse(64'h1111_2222_3333_4444);
      chk("rml_wen",  wb.rf_wen,     0);
      chk("rml_cnt",  wb.retire_cnt, 0);
      chk("rml_busy", wb.busy,       0);
      @(negedge clk);
      chk("rml_wen2", wb.rf_wen,     0);

      // Reset during COMMIT drops the write
      issue(1'b0, 5'd6, 1'b1, 64'h77, 3'd0, 3'd0);
      chk("rmc_wen1", wb.rf_wen, 1);
      rst = 1'b1;
      #1;
      chk("rmc_wen0", wb.rf_wen,     0);
      chk("rmc_cnt",  wb.retire_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // Counter wrap
      @(negedge clk);
      force dut.retire_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_q;
      #1;
      chk("wrap_pre", wb.retire_cnt, 32'hFFFF_FFFF);
      issue(1'b0, 5'd1, 1'b1, 64'h9, 3'd0, 3'd0);
      chk("wrap_cnt", wb.retire_cnt, 0);
      chk("wrap_wen", wb.rf_wen,     1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL use a single clock `clk` and an asynchronous, active-high reset `rst`.
REQ-002 Parameter XLEN, default 64: width of the register write-back data.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 in_valid  in  1  upstream instruction result valid.
REQ-006 in_ready  out  1  block can accept a result this cycle.
REQ-007 in_rd  in  5  destination register index.
REQ-008 in_wen  in  1  instruction writes rd.
REQ-009 in_is_load  in  1  result comes from memory, not the ALU.
REQ-010 in_alu_result  in  XLEN  ALU result.
REQ-011 in_load_fmt  in  3  RISC-V load funct3 (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110).
REQ-012 in_addr_low  in  3  load address bits [2:0].
REQ-013 mem_rvalid  in  1  load data valid, one-cycle pulse.
REQ-014 mem_rdata  in  64  aligned doubleword returned by memory.
REQ-015 rf_wen  out  1  register file write strobe.
REQ-016 rf_rdAddr  out  5  register file write index.
REQ-017 rf_dataBack  out  XLEN  register file write data.
REQ-018 busy  out  1  block holds an instruction.
REQ-019 retire_cnt  out  32  count of retired instructions.

Function
REQ-020 States: IDLE, WAIT_MEM, COMMIT; busy = (state != IDLE).
REQ-021 in_ready = 1 only in IDLE; an accept occurs when in_valid && in_ready at a rising edge.
REQ-022 On a non-load accept: latch rd, wen and alu_result, then go to COMMIT; the write appears in the cycle after the accept.
REQ-023 On a load accept: latch rd, wen, fmt and addr_low, then go to WAIT_MEM.
REQ-024 WAIT_MEM stays until mem_rvalid=1; the extracted data is captured on that edge; next state is COMMIT.
REQ-025 mem_rvalid is ignored in IDLE and COMMIT.
REQ-026 Extraction: LB/LBU take byte addr_low; LH/LHU take halfword addr_low[2:1]; LW/LWU take word addr_low[2]; LD takes all 64 bits.
REQ-027 Alignment: for halfword/word/doubleword loads, the unused low address bits are ignored (forced alignment, no trap).
REQ-028 Extension: LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend; fmt 111 yields 0.
REQ-029 COMMIT lasts exactly one cycle, then returns to IDLE; throughput is at most one instruction per 2 cycles.
REQ-030 rf_wen = 1 only in COMMIT and only when latched wen=1 and rd != 0; x0 is never written.
REQ-031 rf_rdAddr and rf_dataBack are registered; they change only when entering COMMIT and hold their values otherwise.
REQ-032 retire_cnt increments by 1 on every COMMIT cycle, including rd=0 and wen=0 cases.
REQ-033 retire_cnt wraps from 0xFFFF_FFFF to 0.

Reset
REQ-034 Asserting rst forces, immediately: state IDLE, rf_wen 0, rf_rdAddr 0, rf_dataBack 0, retire_cnt 0, busy 0, in_ready 1.
REQ-035 Reset in WAIT_MEM or COMMIT aborts the held instruction; no write occurs and the instruction is not counted.
REQ-036 A mem_rvalid arriving after reset release with no load pending is ignored.

Verification
REQ-037 ALU path: accept rd=5, wen=1, alu=0x1234 at edge T -> at T+1 rf_wen=1, rf_rdAddr=5, rf_dataBack=0x1234, retire_cnt=1, in_ready=0; at T+2 in_ready=1, rf_wen=0.
REQ-038 LB sign-extend: fmt=000, addr_low=3, rd=7; mem_rvalid 3 cycles later with mem_rdata=0x0000_0000_8000_0000 -> next cycle rf_wen=1, rd=7, data=0xFFFF_FFFF_FFFF_FF80.
REQ-039 LWU upper word: fmt=110, addr_low=4, mem_rdata=0xDEAD_BEEF_0000_0000 -> data=0x0000_0000_DEAD_BEEF; the same load with LW -> 0xFFFF_FFFF_DEAD_BEEF.
REQ-040 x0 write: rd=0, wen=1, alu=0xFF -> rf_wen stays 0, retire_cnt increments by 1.
REQ-041 Reset mid-load: accept load, assert rst in WAIT_MEM, release, then pulse mem_rvalid -> no rf_wen, retire_cnt=0, busy=0.
REQ-042 Wrap: force retire_cnt to 0xFFFF_FFFF, commit one ALU op -> retire_cnt=0.
